// File: rtl/rename_reg_file_pkg.sv
// Shared definitions for the rename register file.
//   - Default widths and lane counts used by the interface and the modules.
//   - ROB_NONE: the ROB id meaning "no pending producer".
//   - lane_lo(): low bit of lane k in a flattened lane bus.
package rename_reg_file_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned REGBW_DEF = 5;
  localparam int unsigned ROBBW_DEF = 4;
  localparam int unsigned W_DEF     = 2;
  localparam int unsigned NCDB_DEF  = 2;
  localparam int unsigned NCKPT_DEF = 4;

  localparam int unsigned ROB_NONE = 0;

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/rename_reg_file_if.sv
// Bus between dispatch/ROB/CDB and the rename register file.
//   master: front end side.
//     Drives rdy, flush, source indices, ROB query replies, CDBs, commits, renames and
//     checkpoint controls.
//   slave: the register file.
//     Returns operand value/tag, ROB query ids and ck_valid.
// Lane k of every flattened bus occupies bits [k*w +: w].
interface rename_reg_file_if
  import rename_reg_file_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned REGBW = REGBW_DEF,
  parameter int unsigned ROBBW = ROBBW_DEF,
  parameter int unsigned W     = W_DEF,
  parameter int unsigned NCDB  = NCDB_DEF,
  parameter int unsigned NCKPT = NCKPT_DEF
);
  localparam int unsigned CKBW = (NCKPT > 1) ? $clog2(NCKPT) : 1;

  logic                   rdy;
  logic                   flush;
  logic [2*W*REGBW-1:0]   rs;
  logic [2*W*XLEN-1:0]    val_out;
  logic [2*W*ROBBW-1:0]   tag_out;
  logic [2*W*ROBBW-1:0]   rob_qid;
  logic [2*W-1:0]         rob_qrdy;
  logic [2*W*XLEN-1:0]    rob_qval;
  logic [NCDB-1:0]        cdb_vld;
  logic [NCDB*ROBBW-1:0]  cdb_id;
  logic [NCDB*XLEN-1:0]   cdb_val;
  logic [W-1:0]           cm_vld;
  logic [W*REGBW-1:0]     cm_rd;
  logic [W*ROBBW-1:0]     cm_id;
  logic [W*XLEN-1:0]      cm_val;
  logic [W-1:0]           rn_vld;
  logic [W*REGBW-1:0]     rn_rd;
  logic [W*ROBBW-1:0]     rn_id;
  logic                   ck_take;
  logic [CKBW-1:0]        ck_idx;
  logic                   ck_restore;
  logic [CKBW-1:0]        ck_ridx;
  logic [NCKPT-1:0]       ck_valid;

  modport master (
    output rdy, flush, rs, rob_qrdy, rob_qval, cdb_vld, cdb_id, cdb_val,
           cm_vld, cm_rd, cm_id, cm_val, rn_vld, rn_rd, rn_id,
           ck_take, ck_idx, ck_restore, ck_ridx,
    input  val_out, tag_out, rob_qid, ck_valid
  );

  modport slave (
    input  rdy, flush, rs, rob_qrdy, rob_qval, cdb_vld, cdb_id, cdb_val,
           cm_vld, cm_rd, cm_id, cm_val, rn_vld, rn_rd, rn_id,
           ck_take, ck_idx, ck_restore, ck_ridx,
    output val_out, tag_out, rob_qid, ck_valid
  );

endinterface

// File: rtl/rrf_operand_mux.sv
// Single read port value/tag resolve.
//   rs, reg_val, reg_tag : source index and its current file entry
//   qrdy, qval           : ROB reply for the looked-up tag
//   cdb_*                : CDB broadcasts; the lowest matching channel wins
//   val, tag             : resolved operand (val 0 whenever tag != 0)
//   qid                  : tag forwarded to the ROB for lookup
module rrf_operand_mux
  import rename_reg_file_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned REGBW = REGBW_DEF,
  parameter int unsigned ROBBW = ROBBW_DEF,
  parameter int unsigned NCDB  = NCDB_DEF
) (
  input  logic [REGBW-1:0]      rs,
  input  logic [XLEN-1:0]       reg_val,
  input  logic [ROBBW-1:0]      reg_tag,
  input  logic                  qrdy,
  input  logic [XLEN-1:0]       qval,
  input  logic [NCDB-1:0]       cdb_vld,
  input  logic [NCDB*ROBBW-1:0] cdb_id,
  input  logic [NCDB*XLEN-1:0]  cdb_val,
  output logic [XLEN-1:0]       val,
  output logic [ROBBW-1:0]      tag,
  output logic [ROBBW-1:0]      qid
);

  logic hit;

  assign qid = reg_tag;

  always_comb begin
    val = '0;
    tag = ROBBW'(ROB_NONE);
    hit = 1'b0;
    if (rs == '0 || reg_tag == ROBBW'(ROB_NONE)) begin
      val = reg_val;
    end else if (qrdy) begin
      val = qval;
    end else begin
      for (int unsigned c = 0; c < NCDB; c++) begin
        if (!hit && cdb_vld[c] && cdb_id[c*ROBBW +: ROBBW] == reg_tag) begin
          hit = 1'b1;
          val = cdb_val[c*XLEN +: XLEN];
        end
      end
      if (!hit) tag = reg_tag;
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file plus rename-tag table with branch checkpoints.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rename_reg_file_if slave (reads, commits, renames, checkpoints)
// Reads are combinational from pre-edge state. Commits write values and clear matching
// tags; renames then overwrite tags (higher lane wins). Snapshots hold whole tag tables
// and are scrubbed by every commit so a restore never brings back a retired id.
module rename_reg_file
  import rename_reg_file_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned REGBW = REGBW_DEF,
  parameter int unsigned ROBBW = ROBBW_DEF,
  parameter int unsigned W     = W_DEF,
  parameter int unsigned NCDB  = NCDB_DEF,
  parameter int unsigned NCKPT = NCKPT_DEF
) (
  input logic               clk,
  input logic               rst,
  rename_reg_file_if.slave  bus
);

  localparam int unsigned NREG  = 2 ** REGBW;
  localparam int unsigned NPORT = 2 * W;

  logic [XLEN-1:0]  value_q [NREG];
  logic [XLEN-1:0]  value_d [NREG];
  logic [XLEN-1:0]  value_c [NREG];
  logic [ROBBW-1:0] tag_q   [NREG];
  logic [ROBBW-1:0] tag_d   [NREG];
  logic [ROBBW-1:0] tag_cm  [NREG];
  logic [ROBBW-1:0] tag_rn  [NREG];
  logic [ROBBW-1:0] snap_q  [NCKPT][NREG];
  logic [ROBBW-1:0] snap_d  [NCKPT][NREG];
  logic [ROBBW-1:0] snap_cm [NCKPT][NREG];
  logic [NCKPT-1:0] ck_valid_q, ck_valid_d;

  // Read ports
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    logic [REGBW-1:0] rs_p;
    assign rs_p = bus.rs[p*REGBW +: REGBW];
    rrf_operand_mux #(
      .XLEN  (XLEN),
      .REGBW (REGBW),
      .ROBBW (ROBBW),
      .NCDB  (NCDB)
    ) u_mux (
      .rs      (rs_p),
      .reg_val (value_q[rs_p]),
      .reg_tag (tag_q[rs_p]),
      .qrdy    (bus.rob_qrdy[p]),
      .qval    (bus.rob_qval[p*XLEN +: XLEN]),
      .cdb_vld (bus.cdb_vld),
      .cdb_id  (bus.cdb_id),
      .cdb_val (bus.cdb_val),
      .val     (bus.val_out[p*XLEN +: XLEN]),
      .tag     (bus.tag_out[p*ROBBW +: ROBBW]),
      .qid     (bus.rob_qid[p*ROBBW +: ROBBW])
    );
  end

  assign bus.ck_valid = ck_valid_q;

  // Commits: value write is unconditional, tag clear only on id match.
  always_comb begin
    value_c = value_q;
    tag_cm  = tag_q;
    for (int unsigned k = 0; k < W; k++) begin
      if (bus.cm_vld[k] && bus.cm_rd[lane_lo(k, REGBW) +: REGBW] != '0) begin
        value_c[bus.cm_rd[lane_lo(k, REGBW) +: REGBW]] = bus.cm_val[lane_lo(k, XLEN) +: XLEN];
        if (tag_q[bus.cm_rd[lane_lo(k, REGBW) +: REGBW]] == bus.cm_id[lane_lo(k, ROBBW) +: ROBBW])
          tag_cm[bus.cm_rd[lane_lo(k, REGBW) +: REGBW]] = ROBBW'(ROB_NONE);
      end
    end
  end

  // Renames layered over the commit result, so a rename beats a same-rd tag clear.
  always_comb begin
    tag_rn = tag_cm;
    for (int unsigned k = 0; k < W; k++) begin
      if (bus.rn_vld[k] && bus.rn_rd[lane_lo(k, REGBW) +: REGBW] != '0)
        tag_rn[bus.rn_rd[lane_lo(k, REGBW) +: REGBW]] = bus.rn_id[lane_lo(k, ROBBW) +: ROBBW];
    end
    tag_rn[0] = ROBBW'(ROB_NONE);
  end

  // Scrub committing ids out of every snapshot.
  always_comb begin
    snap_cm = snap_q;
    for (int unsigned s = 0; s < NCKPT; s++) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        for (int unsigned k = 0; k < W; k++) begin
          if (bus.cm_vld[k] && snap_q[s][r] == bus.cm_id[lane_lo(k, ROBBW) +: ROBBW])
            snap_cm[s][r] = ROBBW'(ROB_NONE);
        end
      end
    end
  end

  always_comb begin
    value_d    = value_q;
    tag_d      = tag_q;
    snap_d     = snap_q;
    ck_valid_d = ck_valid_q;
    // A restore from an empty slot has nothing safe to return to, so it acts as a flush.
    if (bus.flush || (bus.rdy && bus.ck_restore && !ck_valid_q[bus.ck_ridx])) begin
      for (int unsigned r = 0; r < NREG; r++) tag_d[r] = ROBBW'(ROB_NONE);
      ck_valid_d = '0;
    end else if (bus.rdy) begin
      value_d = value_c;
      snap_d  = snap_cm;
      if (bus.ck_restore) begin
        for (int unsigned r = 0; r < NREG; r++) tag_d[r] = snap_cm[bus.ck_ridx][r];
        ck_valid_d[bus.ck_ridx] = 1'b0;
      end else begin
        tag_d = tag_rn;
        if (bus.ck_take) begin
          for (int unsigned r = 0; r < NREG; r++) snap_d[bus.ck_idx][r] = tag_rn[r];
          ck_valid_d[bus.ck_idx] = 1'b1;
        end
      end
    end
    tag_d[0]   = ROBBW'(ROB_NONE);
    value_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        value_q[r] <= '0;
        tag_q[r]   <= '0;
        for (int unsigned s = 0; s < NCKPT; s++) snap_q[s][r] <= '0;
      end
      ck_valid_q <= '0;
    end else begin
      value_q    <= value_d;
      tag_q      <= tag_d;
      snap_q     <= snap_d;
      ck_valid_q <= ck_valid_d;
    end
  end

  restore_slot_valid: assert property (@(posedge clk) disable iff (rst)
    (bus.rdy && !bus.flush && bus.ck_restore) |-> ck_valid_q[bus.ck_ridx]);

endmodule

// File: tb/tb_rename_reg_file.sv
module tb_rename_reg_file;
  import rename_reg_file_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REGBW = 5;
  localparam int unsigned ROBBW = 4;

  typedef struct {
    string       name;
    logic [31:0] val;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  rename_reg_file_if bus ();

  rename_reg_file u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rdy        = 1'b1;
    bus.flush      = 1'b0;
    bus.rs         = '0;
    bus.rob_qrdy   = '0;
    bus.rob_qval   = '0;
    bus.cdb_vld    = '0;
    bus.cdb_id     = '0;
    bus.cdb_val    = '0;
    bus.cm_vld     = '0;
    bus.cm_rd      = '0;
    bus.cm_id      = '0;
    bus.cm_val     = '0;
    bus.rn_vld     = '0;
    bus.rn_rd      = '0;
    bus.rn_id      = '0;
    bus.ck_take    = 1'b0;
    bus.ck_idx     = '0;
    bus.ck_restore = 1'b0;
    bus.ck_ridx    = '0;
  endtask

  task automatic rn(input int k, input logic [4:0] rd, input logic [3:0] id);
    bus.rn_vld[k]                 = 1'b1;
    bus.rn_rd[k*REGBW +: REGBW]   = rd;
    bus.rn_id[k*ROBBW +: ROBBW]   = id;
  endtask

  task automatic cm(input int k, input logic [4:0] rd, input logic [3:0] id,
                    input logic [31:0] v);
    bus.cm_vld[k]                 = 1'b1;
    bus.cm_rd[k*REGBW +: REGBW]   = rd;
    bus.cm_id[k*ROBBW +: ROBBW]   = id;
    bus.cm_val[k*XLEN +: XLEN]    = v;
  endtask

  // Drive a read, queue the expectation, then pop and compare once the port settles.
  task automatic rd_chk(input int p, input logic [4:0] r, input logic [31:0] ev,
                        input logic [3:0] et, input string name);
    exp_t e;
    bus.rs[p*REGBW +: REGBW] = r;
    e.name = name;
    e.val  = ev;
    e.tag  = et;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    cmp({e.name, ".val"}, bus.val_out[p*XLEN +: XLEN], e.val);
    cmp({e.name, ".tag"}, 32'(bus.tag_out[p*ROBBW +: ROBBW]), 32'(e.tag));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    rd_chk(0, 5, 32'h0, 4'h0, "rst_x5");
    rd_chk(3, 0, 32'h0, 4'h0, "rst_x0");
    cmp("rst_ckv", 32'(bus.ck_valid), 32'h0);

    // Rename then resolve via CDB / ROB
    idle(); rn(0, 5, 3); tick(); idle();
    bus.cdb_vld = 2'b10; bus.cdb_id[4 +: 4] = 4'd3; bus.cdb_val[32 +: 32] = 32'hAA;
    rd_chk(1, 5, 32'hAA, 4'h0, "cdb1_hit");
    cmp("rob_qid", 32'(bus.rob_qid[4 +: 4]), 32'd3);
    bus.cdb_vld = 2'b11; bus.cdb_id[0 +: 4] = 4'd3; bus.cdb_val[0 +: 32] = 32'hBB;
    rd_chk(1, 5, 32'hBB, 4'h0, "cdb_low_wins");
    bus.rob_qrdy[1] = 1'b1; bus.rob_qval[32 +: 32] = 32'h55;
    rd_chk(1, 5, 32'h55, 4'h0, "rob_before_cdb");
    idle();
    rd_chk(1, 5, 32'h0, 4'h3, "pending");

    // Same-cycle renames and commits
    rn(0, 7, 2); rn(1, 7, 4); tick(); idle();
    rd_chk(0, 7, 32'h0, 4'h4, "x7_hi_lane");
    cm(0, 7, 2, 32'd9); tick(); idle();
    rd_chk(0, 7, 32'h0, 4'h4, "x7_stale_commit");
    cm(0, 7, 4, 32'h44); tick(); idle();
    rd_chk(0, 7, 32'h44, 4'h0, "x7_commit");
    cm(0, 8, 5, 32'h88); tick(); idle();
    rd_chk(0, 8, 32'h88, 4'h0, "x8_value_no_match");
    cm(0, 9, 9, 32'd1); cm(1, 9, 9, 32'd2); tick(); idle();
    rd_chk(0, 9, 32'd2, 4'h0, "x9_hi_commit");
    rn(0, 10, 6); tick(); idle();
    cm(0, 10, 6, 32'h10); rn(0, 10, 7); tick(); idle();
    rd_chk(2, 10, 32'h0, 4'h7, "rn_over_cm");
    cm(0, 10, 7, 32'h77); tick(); idle();
    rd_chk(2, 10, 32'h77, 4'h0, "x10_commit");

    // Checkpoint take / restore
    rn(0, 3, 5); bus.ck_take = 1'b1; bus.ck_idx = 2'd1; tick(); idle();
    cmp("take1_ckv", 32'(bus.ck_valid), 32'h2);
    rn(0, 3, 6); tick(); idle();
    rd_chk(0, 3, 32'h0, 4'h6, "x3_renamed");
    cm(0, 3, 5, 32'h11); tick(); idle();
    rd_chk(0, 3, 32'h0, 4'h6, "x3_still6");
    bus.ck_restore = 1'b1; bus.ck_ridx = 2'd1; tick(); idle();
    rd_chk(0, 3, 32'h11, 4'h0, "x3_restored");
    rd_chk(1, 5, 32'h0, 4'h3, "x5_restored");
    cmp("restore1_ckv", 32'(bus.ck_valid), 32'h0);
    rn(0, 11, 8); bus.ck_take = 1'b1; bus.ck_idx = 2'd2; tick(); idle();
    cmp("take2_ckv", 32'(bus.ck_valid), 32'h4);
    cm(0, 11, 8, 32'h22); rn(1, 12, 9);
    bus.ck_restore = 1'b1; bus.ck_ridx = 2'd2; bus.ck_take = 1'b1; bus.ck_idx = 2'd0;
    tick(); idle();
    rd_chk(0, 11, 32'h22, 4'h0, "restore_with_commit");
    rd_chk(1, 12, 32'h0, 4'h0, "restore_drops_rename");
    cmp("restore2_ckv", 32'(bus.ck_valid), 32'h0);

    // x0 stays zero
    rn(0, 0, 7); cm(1, 0, 7, 32'd1); tick(); idle();
    rd_chk(0, 0, 32'h0, 4'h0, "x0_forced");

    // rdy hold and flush
    rn(0, 13, 10); bus.ck_take = 1'b1; bus.ck_idx = 2'd3; tick(); idle();
    cmp("take3_ckv", 32'(bus.ck_valid), 32'h8);
    rd_chk(0, 13, 32'h0, 4'hA, "x13_renamed");
    bus.rdy = 1'b0; rn(0, 2, 1); bus.ck_take = 1'b1; bus.ck_idx = 2'd0; tick(); idle();
    rd_chk(0, 2, 32'h0, 4'h0, "rdy_hold");
    cmp("rdy_hold_ckv", 32'(bus.ck_valid), 32'h8);
    bus.rdy = 1'b0; bus.flush = 1'b1; tick(); idle();
    rd_chk(0, 13, 32'h0, 4'h0, "flush_x13");
    rd_chk(1, 5, 32'h0, 4'h0, "flush_x5");
    rd_chk(2, 3, 32'h11, 4'h0, "flush_keeps_value");
    cmp("flush_ckv", 32'(bus.ck_valid), 32'h0);

    // Reset clears values
    rst = 1'b1; tick(); rst = 1'b0; idle();
    rd_chk(0, 3, 32'h0, 4'h0, "rst_clears_value");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
